button_event_decoder: RTL and testbench



---
 rtl/button_event_decoder.sv | 153 +++++++++++++++
 tb/tb_button_event_decoder.sv | 100 ++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Gesture classifier for one debounced push button: emits one-cycle click,
// double_click, long_press and auto-repeat pulses from debounced level/edge inputs.
`timescale 1ns/1ps
module button_event_decoder #(
  parameter int CNT_W        = 24,
  parameter int LONG_TICKS   = 12500000,
  parameter int REPEAT_TICKS = 2500000,
  parameter int DCLICK_TICKS = 6250000
) (
  input  logic clk,
  input  logic resetn,
  input  logic pb_state,
  input  logic pb_down,
  input  logic pb_up,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             dclick_pend_r;
  logic             click_r;
  logic             double_click_r;
  logic             long_press_r;
  logic             repeat_pulse_r;
  logic             busy_r;

  logic down_s;
  logic up_s;
  logic long_exp_s;
  logic repeat_exp_s;
  logic dclick_exp_s;

  // Qualified edges (simultaneous down+up cancel) and timer expiry decodes.
  always_comb begin
    down_s       = pb_down & ~pb_up;
    up_s         = pb_up & ~pb_down;
    long_exp_s   = (cnt_r == LONG_LAST);
    repeat_exp_s = (cnt_r == REPEAT_LAST);
    dclick_exp_s = (cnt_r == DCLICK_LAST);
  end

  // Gesture FSM with tick counter and registered event pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r        <= IDLE;
      cnt_r          <= '0;
      dclick_pend_r  <= 1'b0;
      click_r        <= 1'b0;
      double_click_r <= 1'b0;
      long_press_r   <= 1'b0;
      repeat_pulse_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      click_r        <= 1'b0;
      long_press_r   <= 1'b0;
      repeat_pulse_r <= 1'b0;
      // double_click lands one cycle after the release that completes it
      double_click_r <= dclick_pend_r;
      dclick_pend_r  <= 1'b0;
      cnt_r          <= cnt_r + CNT_W'(1);
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (down_s) begin
            state_r <= PRESSED;
            busy_r  <= 1'b1;
          end
        end
        PRESSED: begin
          if (up_s) begin
            state_r <= WAIT_SECOND;
            cnt_r   <= '0;
          end else if (!pb_state) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
          end else if (long_exp_s) begin
            long_press_r <= 1'b1;
            state_r      <= LONG_HELD;
            cnt_r        <= '0;
          end
        end
        LONG_HELD: begin
          if (up_s || !pb_state) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
          end else if (repeat_exp_s) begin
            repeat_pulse_r <= 1'b1;
            cnt_r          <= '0;
          end
        end
        WAIT_SECOND: begin
          if (down_s) begin
            state_r <= SECOND_PRESSED;
            cnt_r   <= '0;
          end else if (dclick_exp_s) begin
            click_r <= 1'b1;
            state_r <= IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
          end
        end
        SECOND_PRESSED: begin
          if (up_s) begin
            dclick_pend_r <= 1'b1;
            state_r       <= IDLE;
            cnt_r         <= '0;
            busy_r        <= 1'b0;
          end else if (!pb_state) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
          end else if (long_exp_s) begin
            // the first press is reported as a click alongside the long press
            click_r      <= 1'b1;
            long_press_r <= 1'b1;
            state_r      <= LONG_HELD;
            cnt_r        <= '0;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign click        = click_r;
  assign double_click = double_click_r;
  assign long_press   = long_press_r;
  assign repeat_pulse = repeat_pulse_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed table-driven bench for button_event_decoder with short timing parameters.
`timescale 1ns/1ps
module tb_button_event_decoder;

  localparam int LT = 20;
  localparam int RT = 5;
  localparam int DT = 10;
  localparam int NV = 14;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic pb_state = 1'b0;
  logic pb_down = 1'b0;
  logic pb_up = 1'b0;
  logic click, double_click, long_press, repeat_pulse, busy;

  int n_checks = 0;
  int n_pass = 0;

  button_event_decoder #(
    .CNT_W(8), .LONG_TICKS(LT), .REPEAT_TICKS(RT), .DCLICK_TICKS(DT)
  ) dut (
    .clk(clk), .resetn(resetn), .pb_state(pb_state), .pb_down(pb_down), .pb_up(pb_up),
    .click(click), .double_click(double_click), .long_press(long_press),
    .repeat_pulse(repeat_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  // cycle fields are -1 when unused; press level lasts from dN up to (not incl.) uN
  typedef struct {
    int d1; int u1; int d2; int u2; int d3; int u3;
    int xdn; int xup; int drop; int rlo; int rhi; int len;
    int click_at; int dclick_at; int long_at; int rep1; int repn; int idle_from;
  } vec_t;

  vec_t vecs [NV];

  function automatic bit lvl(int c, int d, int u);
    return (d >= 0) && (c >= d) && ((u < 0) || (c < u));
  endfunction

  task automatic check(string name, int v, int c, logic [3:0] got, logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s vec%0d cycle%0d got %b expected %b", name, v, c, got, exp);
  endtask

  initial begin
    //         d1  u1  d2  u2  d3  u3 xdn xup drop rlo rhi len clk dclk long rep1 repn idle
    vecs[0]  = '{ 0,  5, -1, -1, -1, -1, -1, -1, -1, -1, -1, 25, 15, -1, -1, -1, 0, 16};
    vecs[1]  = '{ 0,  4,  8, 12, -1, -1, -1, -1, -1, -1, -1, 30, -1, 13, -1, -1, 0, 14};
    vecs[2]  = '{ 0, 42, -1, -1, -1, -1, -1, -1, -1, -1, -1, 50, -1, -1, 20, 25, 4, 43};
    vecs[3]  = '{ 0,  4, 14, -1, -1, -1, -1, -1, -1, -1, -1, 30, -1, -1, -1, -1, 0, -1};
    vecs[4]  = '{ 0,  4, 15, -1, -1, -1, -1, -1, -1, -1, -1, 30, 14, -1, -1, -1, 0, -1};
    vecs[5]  = '{ 0,  3,  6, -1, -1, -1, -1, -1, -1, -1, -1, 36, 26, -1, 26, 31, 1, -1};
    vecs[6]  = '{ 0, -1, -1, -1, -1, -1, -1, -1, -1, 10, 12, 30, -1, -1, -1, -1, 0, 10};
    vecs[7]  = '{ 0, -1, -1, -1, -1, -1, -1, -1,  7, -1, -1, 30, -1, -1, -1, -1, 0,  8};
    vecs[8]  = '{-1, -1, -1, -1, -1, -1,  3,  3, -1, -1, -1, 10, -1, -1, -1, -1, 0,  0};
    vecs[9]  = '{ 0,  4, -1, -1, -1, -1, -1,  8, -1, -1, -1, 20, 14, -1, -1, -1, 0, 15};
    vecs[10] = '{ 0,  4,  8, 12, 20, 23, -1, -1, -1, -1, -1, 40, 33, 13, -1, -1, 0, 34};
    vecs[11] = '{ 0, -1, -1, -1, -1, -1,  5,  5, -1, -1, -1, 30, -1, -1, 20, 25, 1, -1};
    vecs[12] = '{ 0, 20, -1, -1, -1, -1, -1, -1, -1, -1, -1, 32, 30, -1, -1, -1, 0, 31};
    vecs[13] = '{ 0, 25, -1, -1, -1, -1, -1, -1, -1, -1, -1, 30, -1, -1, 20, -1, 0, 26};

    for (int v = 0; v < NV; v++) begin
      // reset between vectors, then confirm the reset state
      @(posedge clk); #1;
      resetn = 1'b0; pb_state = 1'b0; pb_down = 1'b0; pb_up = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", v, -1, {click, double_click, long_press, repeat_pulse}, 4'b0000);
      check("reset_busy", v, -1, {3'b000, busy}, 4'b0000);
      resetn = 1'b1;
      for (int c = 0; c < vecs[v].len; c++) begin
        logic [3:0] exp;
        bit rep;
        pb_down  = (c == vecs[v].d1) || (c == vecs[v].d2) || (c == vecs[v].d3) || (c == vecs[v].xdn);
        pb_up    = (c == vecs[v].u1) || (c == vecs[v].u2) || (c == vecs[v].u3) || (c == vecs[v].xup);
        pb_state = (lvl(c, vecs[v].d1, vecs[v].u1) || lvl(c, vecs[v].d2, vecs[v].u2) ||
                    lvl(c, vecs[v].d3, vecs[v].u3)) && !((vecs[v].drop >= 0) && (c >= vecs[v].drop));
        resetn   = !((vecs[v].rlo >= 0) && (c >= vecs[v].rlo) && (c <= vecs[v].rhi));
        @(posedge clk);
        #1;
        rep = (vecs[v].repn > 0) && (c >= vecs[v].rep1) && (((c - vecs[v].rep1) % RT) == 0) &&
              (((c - vecs[v].rep1) / RT) < vecs[v].repn);
        exp = {c == vecs[v].click_at, c == vecs[v].dclick_at, c == vecs[v].long_at, rep};
        check("events", v, c, {click, double_click, long_press, repeat_pulse}, exp);
        if ((vecs[v].idle_from >= 0) && (c >= vecs[v].idle_from))
          check("busy_low", v, c, {3'b000, busy}, 4'b0000);
        if ((vecs[v].d1 == 0) && (c == 1))
          check("busy_high", v, c, {3'b000, busy}, 4'b0001);
      end
    end
    pb_down = 1'b0; pb_up = 1'b0; pb_state = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
